// File: rtl/vproc_pkg.sv
// vproc_pkg -- shared vector-processor definitions.
// Purpose : functional-unit enumeration (index order of the write-request
//           vectors), the write-request record, and the arbiter lock state.
// Ports   : none (package).
package vproc_pkg;

   // Index order of every per-unit vector: LSU, ALU, MUL, SLD, ELEM.
   typedef enum logic [2:0] {
      UNIT_LSU  = 3'd0,
      UNIT_ALU  = 3'd1,
      UNIT_MUL  = 3'd2,
      UNIT_SLD  = 3'd3,
      UNIT_ELEM = 3'd4
   } op_unit;

   localparam int unsigned UNIT_CNT   = 5;
   localparam int unsigned UNIT_IDX_W = 3;

   // Nominal data width of the request record; the arbiter carries VREG_W itself.
   localparam int unsigned VREG_W_PH = 128;

   typedef struct packed {
      logic [4:0]             addr;
      logic [VREG_W_PH-1:0]   data;
      logic [VREG_W_PH/8-1:0] be;
      logic                   last;
   } vreg_wr_req;

   typedef enum logic {
      ARB_FREE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic logic [31:0] addr_onehot(input logic [4:0] addr);
      return 32'(1) << addr;
   endfunction

endpackage

// File: rtl/vproc_vreg_wr_arbiter_if.sv
// vproc_vreg_wr_arbiter_if -- per-unit vector-register write request bus.
// Purpose : bundles the valid/ready request handshake of all functional units.
// Ports   : master (units)   drives req_valid_i/addr/data/be/last, sees req_ready_o
//           slave  (arbiter) sees the requests, drives req_ready_o
interface vproc_vreg_wr_arbiter_if
   import vproc_pkg::*;
#(
   parameter int unsigned VREG_W = 128
);
   logic [UNIT_CNT-1:0]                   req_valid_i;
   logic [UNIT_CNT-1:0]                   req_ready_o;
   logic [UNIT_CNT-1:0][4:0]              req_addr_i;
   logic [UNIT_CNT-1:0][VREG_W-1:0]       req_data_i;
   logic [UNIT_CNT-1:0][VREG_W/8-1:0]     req_be_i;
   logic [UNIT_CNT-1:0]                   req_last_i;

   modport master (
      output req_valid_i, req_addr_i, req_data_i, req_be_i, req_last_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, req_be_i, req_last_i,
      output req_ready_o
   );
endinterface

// File: rtl/vproc_rr_pick.sv
// vproc_rr_pick -- combinational round-robin search.
// Purpose : starting at start_i and wrapping modulo N, pick the first set bit
//           of valid_i.
// Ports   : start_i (search start), valid_i (requests)
//           -> grant_o (one-hot), idx_o (winner index), any_o (a winner exists)
module vproc_rr_pick #(
   parameter int unsigned N  = 5,
   parameter int unsigned IW = 3
) (
   input  logic [IW-1:0] start_i,
   input  logic [N-1:0]  valid_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      int unsigned k;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      k       = 0;
      for (int unsigned off = 0; off < N; off++) begin
         k = (32'(start_i) + off) % N;
         if (!any_o && valid_i[k]) begin
            any_o      = 1'b1;
            grant_o[k] = 1'b1;
            idx_o      = IW'(k);
         end
      end
   end

endmodule

// File: rtl/vproc_vreg_wr_arbiter.sv
// vproc_vreg_wr_arbiter -- vector register-file write-port arbiter.
// Purpose : round-robin arbitration of unit write requests with burst locking
//           for multi-register (LMUL>1) writes and a sticky overrun flag.
// Ports   : clk_i, sync_rst_i (sync, active-high)
//           req_if      per-unit request bus (slave side)
//           wr_*_o      register-file write port (optionally registered)
//           pend_clr_o  one-hot of the written register
//           grant_o     current one-hot grant; lock_o burst active; err_o overrun
module vproc_vreg_wr_arbiter
   import vproc_pkg::*;
#(
   parameter int unsigned VREG_W     = 128,
   parameter bit          BUFFER_OUT = 1'b0,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic                       clk_i,
   input  logic                       sync_rst_i,
   vproc_vreg_wr_arbiter_if.slave     req_if,
   output logic                       wr_en_o,
   output logic [4:0]                 wr_addr_o,
   output logic [VREG_W-1:0]          wr_data_o,
   output logic [VREG_W/8-1:0]        wr_be_o,
   output logic [31:0]                pend_clr_o,
   output logic [UNIT_CNT-1:0]        grant_o,
   output logic                       lock_o,
   output logic                       err_o
);

   arb_state_e                state_q, state_d;
   logic [UNIT_IDX_W-1:0]     ptr_q, ptr_d, lock_idx_q, lock_idx_d, gidx;
   logic [2:0]                cnt_q, cnt_d;
   logic                      err_q, err_d, acc;
   logic [UNIT_CNT-1:0]       rr_grant, grant;
   logic [UNIT_IDX_W-1:0]     rr_idx;
   logic                      rr_any;

   vproc_rr_pick #(.N(UNIT_CNT), .IW(UNIT_IDX_W)) u_pick (
      .start_i (ptr_q),
      .valid_i (req_if.req_valid_i),
      .grant_o (rr_grant),
      .idx_o   (rr_idx),
      .any_o   (rr_any)
   );

   function automatic logic [UNIT_IDX_W-1:0] next_idx(input logic [UNIT_IDX_W-1:0] i);
      return (32'(i) == UNIT_CNT - 1) ? '0 : i + UNIT_IDX_W'(1);
   endfunction

   // The register file never back-pressures, so grant == ready == accept.
   always_comb begin
      grant = '0;
      gidx  = lock_idx_q;
      acc   = 1'b0;
      if (!sync_rst_i) begin
         if (state_q == ARB_LOCKED) begin
            // Locked: only the burst owner; an idle owner yields a bubble.
            if (req_if.req_valid_i[lock_idx_q]) begin
               grant[lock_idx_q] = 1'b1;
               acc               = 1'b1;
            end
         end else if (rr_any) begin
            grant = rr_grant;
            gidx  = rr_idx;
            acc   = 1'b1;
         end
      end

      state_d    = state_q;
      ptr_d      = ptr_q;
      lock_idx_d = lock_idx_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      if (acc) begin
         // A last beat ends the burst; the MAX_BURST-th beat without last is
         // forced to end it too and flags the overrun.
         if (req_if.req_last_i[gidx] || cnt_q == 3'(MAX_BURST - 1)) begin
            state_d = ARB_FREE;
            ptr_d   = next_idx(gidx);
            cnt_d   = '0;
            if (!req_if.req_last_i[gidx]) err_d = 1'b1;
         end else begin
            state_d    = ARB_LOCKED;
            lock_idx_d = gidx;
            cnt_d      = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_q    <= ARB_FREE;
         ptr_q      <= '0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign req_if.req_ready_o = grant;
   assign grant_o            = grant;
   assign lock_o             = (state_q == ARB_LOCKED);
   assign err_o              = err_q;

   logic [4:0]          sel_addr;
   logic [VREG_W-1:0]   sel_data;
   logic [VREG_W/8-1:0] sel_be;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_be   = '0;
      if (acc) begin
         sel_addr = req_if.req_addr_i[gidx];
         sel_data = req_if.req_data_i[gidx];
         sel_be   = req_if.req_be_i[gidx];
      end
   end

   generate
      if (BUFFER_OUT) begin : g_buf
         logic                wr_en_q;
         logic [4:0]          wr_addr_q;
         logic [VREG_W-1:0]   wr_data_q;
         logic [VREG_W/8-1:0] wr_be_q;

         // Payload registers only load on an accept, so they hold when idle.
         always_ff @(posedge clk_i) begin
            if (sync_rst_i) begin
               wr_en_q   <= 1'b0;
               wr_addr_q <= '0;
               wr_data_q <= '0;
               wr_be_q   <= '0;
            end else begin
               wr_en_q <= acc;
               if (acc) begin
                  wr_addr_q <= sel_addr;
                  wr_data_q <= sel_data;
                  wr_be_q   <= sel_be;
               end
            end
         end

         assign wr_en_o   = wr_en_q;
         assign wr_addr_o = wr_addr_q;
         assign wr_data_o = wr_data_q;
         assign wr_be_o   = wr_be_q;
      end else begin : g_comb
         assign wr_en_o   = acc;
         assign wr_addr_o = sel_addr;
         assign wr_data_o = sel_data;
         assign wr_be_o   = sel_be;
      end
   endgenerate

   assign pend_clr_o = wr_en_o ? addr_onehot(wr_addr_o) : '0;

endmodule

// File: tb/tb_vproc_vreg_wr_arbiter.sv
// tb_vproc_vreg_wr_arbiter -- scoreboard bench for the write-port arbiter.
// Drives identical directed stimulus into an unbuffered and a buffered
// instance; expected grants/state and expected writes are queued by the
// stimulus and popped by independent monitors.
module tb_vproc_vreg_wr_arbiter;
   import vproc_pkg::*;

   localparam int unsigned VW = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   vproc_vreg_wr_arbiter_if #(.VREG_W(VW)) if0 ();
   vproc_vreg_wr_arbiter_if #(.VREG_W(VW)) if1 ();

   logic [4:0]             tv_valid = '0;
   logic [4:0]             tv_last  = '0;
   logic [4:0][4:0]        tv_addr  = '0;
   logic [4:0][VW-1:0]     tv_data  = '0;
   logic [4:0][VW/8-1:0]   tv_be    = '0;

   assign if0.req_valid_i = tv_valid;
   assign if0.req_last_i  = tv_last;
   assign if0.req_addr_i  = tv_addr;
   assign if0.req_data_i  = tv_data;
   assign if0.req_be_i    = tv_be;
   assign if1.req_valid_i = tv_valid;
   assign if1.req_last_i  = tv_last;
   assign if1.req_addr_i  = tv_addr;
   assign if1.req_data_i  = tv_data;
   assign if1.req_be_i    = tv_be;

   logic          wr_en0, wr_en1, lock0, lock1, err0, err1;
   logic [4:0]    wr_addr0, wr_addr1, grant0, grant1;
   logic [VW-1:0] wr_data0, wr_data1;
   logic [15:0]   wr_be0, wr_be1;
   logic [31:0]   pend0, pend1;

   vproc_vreg_wr_arbiter #(.VREG_W(VW), .BUFFER_OUT(1'b0), .MAX_BURST(8)) dut0 (
      .clk_i(clk), .sync_rst_i(rst), .req_if(if0),
      .wr_en_o(wr_en0), .wr_addr_o(wr_addr0), .wr_data_o(wr_data0), .wr_be_o(wr_be0),
      .pend_clr_o(pend0), .grant_o(grant0), .lock_o(lock0), .err_o(err0)
   );

   vproc_vreg_wr_arbiter #(.VREG_W(VW), .BUFFER_OUT(1'b1), .MAX_BURST(8)) dut1 (
      .clk_i(clk), .sync_rst_i(rst), .req_if(if1),
      .wr_en_o(wr_en1), .wr_addr_o(wr_addr1), .wr_data_o(wr_data1), .wr_be_o(wr_be1),
      .pend_clr_o(pend1), .grant_o(grant1), .lock_o(lock1), .err_o(err1)
   );

   typedef struct { int cyc; logic [4:0] grant; logic lock; logic err; } ctl_exp_t;
   typedef struct { int cyc; logic [4:0] addr; logic [VW-1:0] data; logic [15:0] be; } wr_exp_t;

   ctl_exp_t cq[$];
   wr_exp_t  wq0[$];
   wr_exp_t  wq1[$];
   ctl_exp_t ce;
   wr_exp_t  we0, we1;

   int tests = 0;
   int fails = 0;

   function automatic void chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endfunction

   // Control monitor: grant/ready/lock/err of both instances each cycle.
   always @(negedge clk) begin
      if (cq.size() > 0) begin
         ce = cq.pop_front();
         chk("ctl_cycle", VW'(cyc),  VW'(ce.cyc));
         chk("grant0",    VW'(grant0), VW'(ce.grant));
         chk("ready0",    VW'(if0.req_ready_o), VW'(ce.grant));
         chk("grant1",    VW'(grant1), VW'(ce.grant));
         chk("ready1",    VW'(if1.req_ready_o), VW'(ce.grant));
         chk("lock0",     VW'(lock0), VW'(ce.lock));
         chk("lock1",     VW'(lock1), VW'(ce.lock));
         chk("err0",      VW'(err0),  VW'(ce.err));
         chk("err1",      VW'(err1),  VW'(ce.err));
      end
   end

   // Write monitor, unbuffered: write shows in the accept cycle, zeros when idle.
   always @(negedge clk) begin
      if (wr_en0) begin
         if (wq0.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr0_unexpected cycle=%0d actual_addr=%0d expected=no_write", cyc, wr_addr0);
         end else begin
            we0 = wq0.pop_front();
            chk("wr0_cycle", VW'(cyc), VW'(we0.cyc));
            chk("wr0_addr",  VW'(wr_addr0), VW'(we0.addr));
            chk("wr0_data",  wr_data0, we0.data);
            chk("wr0_be",    VW'(wr_be0), VW'(we0.be));
            chk("wr0_pend",  VW'(pend0), VW'(32'(1) << we0.addr));
         end
      end else if (!rst) begin
         chk("wr0_idle", VW'({pend0, wr_addr0, wr_be0}) | wr_data0, '0);
      end
   end

   // Write monitor, buffered: write shows exactly one cycle after the accept.
   always @(negedge clk) begin
      if (wr_en1) begin
         if (wq1.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr1_unexpected cycle=%0d actual_addr=%0d expected=no_write", cyc, wr_addr1);
         end else begin
            we1 = wq1.pop_front();
            chk("wr1_cycle", VW'(cyc), VW'(we1.cyc + 1));
            chk("wr1_addr",  VW'(wr_addr1), VW'(we1.addr));
            chk("wr1_data",  wr_data1, we1.data);
            chk("wr1_be",    VW'(wr_be1), VW'(we1.be));
            chk("wr1_pend",  VW'(pend1), VW'(32'(1) << we1.addr));
         end
      end else begin
         chk("wr1_pend_idle", VW'(pend1), '0);
      end
   end

   task automatic set_unit(input int u, input bit v, input int a, input bit l);
      tv_valid[u] = v;
      tv_addr[u]  = 5'(a);
      tv_last[u]  = l;
      tv_data[u]  = {16{8'(u * 40 + a)}};
      tv_be[u]    = 16'hFFFF ^ 16'(u + 1);
   endtask

   // One cycle: queue hand-computed expectations, then advance past the edge.
   task automatic step(input logic [4:0] eg, input bit el, input bit ee, input bit r);
      ctl_exp_t c;
      wr_exp_t  w;
      rst     = r;
      c.cyc   = cyc;
      c.grant = eg;
      c.lock  = el;
      c.err   = ee;
      cq.push_back(c);
      for (int u = 0; u < 5; u++) begin
         if (eg[u]) begin
            w.cyc  = cyc;
            w.addr = tv_addr[u];
            w.data = tv_data[u];
            w.be   = tv_be[u];
            wq0.push_back(w);
            wq1.push_back(w);
         end
      end
      @(posedge clk);
      #1;
   endtask

   localparam int LSU  = int'(UNIT_LSU);
   localparam int ALU  = int'(UNIT_ALU);
   localparam int MUL  = int'(UNIT_MUL);
   localparam int SLD  = int'(UNIT_SLD);
   localparam int ELEM = int'(UNIT_ELEM);

   initial begin
      @(posedge clk);
      #1;
      // Reset held with requests pending: no ready, clean state.
      set_unit(ALU, 1, 1, 1);
      set_unit(MUL, 1, 2, 1);
      step(5'b00000, 0, 0, 1);

      // ALU+MUL single beats from ptr=0, then probe ptr=3 and wrap.
      step(5'b00010, 0, 0, 0);
      set_unit(ALU, 0, 1, 1);
      step(5'b00100, 0, 0, 0);
      set_unit(MUL, 0, 2, 1);
      set_unit(LSU, 1, 4, 1);
      set_unit(ALU, 1, 5, 1);
      set_unit(SLD, 1, 6, 1);
      step(5'b01000, 0, 0, 0);
      set_unit(SLD, 0, 6, 1);
      step(5'b00001, 0, 0, 0);
      set_unit(LSU, 0, 4, 1);
      step(5'b00010, 0, 0, 0);
      set_unit(ALU, 0, 5, 1);
      step(5'b00000, 0, 0, 0);

      // LSU 4-beat burst v8..v11 with ALU waiting (ptr=2).
      set_unit(ALU, 1, 7, 1);
      set_unit(LSU, 1, 8, 0);
      step(5'b00001, 0, 0, 0);
      set_unit(LSU, 1, 9, 0);
      step(5'b00001, 1, 0, 0);
      set_unit(LSU, 1, 10, 0);
      step(5'b00001, 1, 0, 0);
      set_unit(LSU, 1, 11, 1);
      step(5'b00001, 1, 0, 0);
      set_unit(LSU, 0, 11, 1);
      step(5'b00010, 0, 0, 0);
      set_unit(ALU, 0, 7, 1);
      step(5'b00000, 0, 0, 0);

      // LSU burst with a 2-cycle gap while ELEM waits (ptr=2 -> ELEM first).
      set_unit(ELEM, 1, 15, 1);
      set_unit(LSU, 1, 12, 0);
      step(5'b10000, 0, 0, 0);
      set_unit(ELEM, 1, 16, 1);
      step(5'b00001, 0, 0, 0);
      set_unit(LSU, 0, 13, 1);
      step(5'b00000, 1, 0, 0);
      step(5'b00000, 1, 0, 0);
      set_unit(LSU, 1, 13, 1);
      step(5'b00001, 1, 0, 0);
      set_unit(LSU, 0, 13, 1);
      step(5'b10000, 0, 0, 0);
      set_unit(ELEM, 0, 16, 1);
      step(5'b00000, 0, 0, 0);

      // SLD overrun: 8 beats without last, ELEM waiting (ptr=0).
      set_unit(ELEM, 1, 30, 1);
      for (int i = 0; i < 8; i++) begin
         set_unit(SLD, 1, 16 + i, 0);
         step(5'b01000, (i != 0), 0, 0);
      end
      set_unit(SLD, 1, 24, 0);
      step(5'b10000, 0, 1, 0);
      set_unit(ELEM, 0, 30, 1);
      step(5'b01000, 0, 1, 0);
      set_unit(SLD, 1, 25, 1);
      step(5'b01000, 1, 1, 0);
      set_unit(SLD, 0, 25, 1);
      step(5'b00000, 0, 1, 0);

      // Reset during beat 2 of an LSU burst (ptr=4), then LSU/ALU together.
      set_unit(LSU, 1, 20, 0);
      step(5'b00001, 0, 1, 0);
      set_unit(LSU, 1, 21, 0);
      step(5'b00000, 1, 1, 1);
      set_unit(LSU, 1, 22, 1);
      set_unit(ALU, 1, 3, 1);
      tv_data[ALU] = {16{8'hA5}};
      tv_be[ALU]   = '1;
      step(5'b00001, 0, 0, 0);
      set_unit(LSU, 0, 22, 1);
      step(5'b00010, 0, 0, 0);
      set_unit(ALU, 0, 3, 1);
      for (int i = 0; i < 3; i++) step(5'b00000, 0, 0, 0);

      @(negedge clk);
      chk("ctl_queue_drained", VW'(cq.size()), '0);
      chk("wr0_queue_drained", VW'(wq0.size()), '0);
      chk("wr1_queue_drained", VW'(wq1.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
